// File: rtl/regfile_onehot.sv
// Register file with one-hot write enable, two combinational read ports and a hardwired-zero top register.
// Optional same-cycle write-through to the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_onehot #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int ZREG  = DEPTH - 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [DEPTH-1:0]         i_wr_onehot,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr1,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr2,
  output logic [WIDTH-1:0]         o_rd_data1,
  output logic [WIDTH-1:0]         o_rd_data2,
  output logic                     o_onehot_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ZIDX = AW'(ZREG);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             r_onehot_err;

  logic             w_wr_any;
  logic             w_wr_multi;
  logic             w_wr_legal;
  logic [AW-1:0]    w_wr_idx;
  logic             w_wr_commit;

  // Clearing the lowest set bit leaves a nonzero vector only when two or more bits were set.
  assign w_wr_any    = |i_wr_onehot;
  assign w_wr_multi  = |(i_wr_onehot & (i_wr_onehot - DEPTH'(1)));
  assign w_wr_legal  = w_wr_any & ~w_wr_multi;
  assign w_wr_commit = w_wr_legal & (w_wr_idx != ZIDX);

  always_comb begin
    w_wr_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_wr_onehot[i]) begin
        w_wr_idx = w_wr_idx | AW'(i);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_commit) begin
      r_regs[w_wr_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_onehot_err <= 1'b0;
    end else if (w_wr_multi) begin
      r_onehot_err <= 1'b1;
    end
  end

  assign o_onehot_err = r_onehot_err;

  // Reset and the zero register override both the stored value and any bypass.
  always_comb begin
    o_rd_data1 = r_regs[i_rd_addr1];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_commit && (w_wr_idx == i_rd_addr1)) begin
      o_rd_data1 = i_wr_data;
    end
`endif
    if (i_reset || (i_rd_addr1 == ZIDX)) begin
      o_rd_data1 = '0;
    end
  end

  always_comb begin
    o_rd_data2 = r_regs[i_rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_commit && (w_wr_idx == i_rd_addr2)) begin
      o_rd_data2 = i_wr_data;
    end
`endif
    if (i_reset || (i_rd_addr2 == ZIDX)) begin
      o_rd_data2 = '0;
    end
  end

endmodule
